// File: rtl/axi_wr_sched.sv
// Shares one AXI write master port between NrReq requesters: round-robin AW
// arbitration, with W and B routed in AW order through two small index FIFOs.
module axi_wr_sched #(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_aw_t       = logic,
  parameter type         axi_w_t        = logic,
  parameter type         axi_b_t        = logic
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_aw_t [NrReq-1:0] req_aw_i,
  input  logic    [NrReq-1:0] req_aw_valid_i,
  output logic    [NrReq-1:0] req_aw_ready_o,
  input  axi_w_t  [NrReq-1:0] req_w_i,
  input  logic    [NrReq-1:0] req_w_valid_i,
  output logic    [NrReq-1:0] req_w_ready_o,
  output axi_b_t  [NrReq-1:0] req_b_o,
  output logic    [NrReq-1:0] req_b_valid_o,
  input  logic    [NrReq-1:0] req_b_ready_i,
  output axi_aw_t             axi_aw_o,
  output logic                axi_aw_valid_o,
  input  logic                axi_aw_ready_i,
  output axi_w_t              axi_w_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  input  axi_b_t              axi_b_i,
  input  logic                axi_b_valid_i,
  output logic                axi_b_ready_o,
  output logic                busy_o
);

  // Every channel is AXI valid/ready: a beat transfers on a rising edge with
  // both high. The W beat's last flag is bit 0 of the flattened W payload.
  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam idx_t LastIdx = idx_t'(NrReq - 1);
  localparam ptr_t LastPtr = ptr_t'(MaxOutstanding - 1);
  localparam cnt_t FullCnt = cnt_t'(MaxOutstanding);

  idx_t    w_mem_q [MaxOutstanding];
  idx_t    b_mem_q [MaxOutstanding];
  ptr_t    w_wr_q, w_wr_d, w_rd_q, w_rd_d;
  ptr_t    b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  cnt_t    w_cnt_q, w_cnt_d, b_cnt_q, b_cnt_d;
  idx_t    rr_pnt_q, rr_pnt_d;
  logic    aw_lock_q, aw_lock_d;
  idx_t    aw_idx_q, aw_idx_d;
  axi_aw_t aw_pay_q, aw_pay_d;

  idx_t arb_idx, arb_cand, grant_idx, w_head, b_head;
  logic arb_found, aw_hs, w_pop, b_pop;
  logic [$bits(axi_w_t)-1:0] w_bits;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic cnt_t cnt_next(cnt_t c, logic push, logic pop);
    case ({push, pop})
      2'b10:   return c + cnt_t'(1);
      2'b01:   return c - cnt_t'(1);
      default: return c;
    endcase
  endfunction

  // AW: once presented, the grant and its payload are held in a lock until
  // the handshake, so later request changes cannot disturb the master port.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_pnt_q;
    arb_cand  = '0;
    for (int i = 0; i < int'(NrReq); i++) begin
      arb_cand = idx_t'((int'(rr_pnt_q) + i) % int'(NrReq));
      if (!arb_found && req_aw_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
    grant_idx      = aw_lock_q ? aw_idx_q : arb_idx;
    axi_aw_valid_o = rst_ni && (aw_lock_q || arb_found) &&
                     (w_cnt_q != FullCnt) && (b_cnt_q != FullCnt);
    axi_aw_o       = '0;
    if (axi_aw_valid_o) axi_aw_o = aw_lock_q ? aw_pay_q : req_aw_i[arb_idx];
    aw_hs          = axi_aw_valid_o && axi_aw_ready_i;
    req_aw_ready_o = '0;
    if (aw_hs) req_aw_ready_o[grant_idx] = 1'b1;

    aw_lock_d = aw_lock_q;
    aw_idx_d  = aw_idx_q;
    aw_pay_d  = aw_pay_q;
    rr_pnt_d  = rr_pnt_q;
    if (aw_hs) begin
      aw_lock_d = 1'b0;
      rr_pnt_d  = (grant_idx == LastIdx) ? '0 : grant_idx + idx_t'(1);
    end else if (axi_aw_valid_o && !aw_lock_q) begin
      aw_lock_d = 1'b1;
      aw_idx_d  = arb_idx;
      aw_pay_d  = req_aw_i[arb_idx];
    end
  end

  // W follows the registered head of the W-order FIFO only.
  always_comb begin
    w_head        = w_mem_q[w_rd_q];
    axi_w_valid_o = 1'b0;
    axi_w_o       = '0;
    req_w_ready_o = '0;
    if (w_cnt_q != '0) begin
      axi_w_valid_o         = req_w_valid_i[w_head];
      axi_w_o               = req_w_i[w_head];
      req_w_ready_o[w_head] = axi_w_ready_i;
    end
    w_bits = axi_w_o;
    w_pop  = axi_w_valid_o && axi_w_ready_i && w_bits[0];
  end

  always_comb begin
    b_head        = b_mem_q[b_rd_q];
    req_b_o       = '0;
    req_b_valid_o = '0;
    axi_b_ready_o = 1'b0;
    if (b_cnt_q != '0) begin
      req_b_o[b_head]       = axi_b_i;
      req_b_valid_o[b_head] = axi_b_valid_i;
      axi_b_ready_o         = req_b_ready_i[b_head];
    end
    b_pop  = axi_b_valid_i && axi_b_ready_o;
    busy_o = (b_cnt_q != '0);
  end

  always_comb begin
    w_wr_d  = aw_hs ? ptr_inc(w_wr_q) : w_wr_q;
    b_wr_d  = aw_hs ? ptr_inc(b_wr_q) : b_wr_q;
    w_rd_d  = w_pop ? ptr_inc(w_rd_q) : w_rd_q;
    b_rd_d  = b_pop ? ptr_inc(b_rd_q) : b_rd_q;
    w_cnt_d = cnt_next(w_cnt_q, aw_hs, w_pop);
    b_cnt_d = cnt_next(b_cnt_q, aw_hs, b_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        w_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
      w_wr_q    <= '0;
      w_rd_q    <= '0;
      b_wr_q    <= '0;
      b_rd_q    <= '0;
      w_cnt_q   <= '0;
      b_cnt_q   <= '0;
      rr_pnt_q  <= '0;
      aw_lock_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_pay_q  <= '0;
    end else begin
      if (aw_hs) begin
        w_mem_q[w_wr_q] <= grant_idx;
        b_mem_q[b_wr_q] <= grant_idx;
      end
      w_wr_q    <= w_wr_d;
      w_rd_q    <= w_rd_d;
      b_wr_q    <= b_wr_d;
      b_rd_q    <= b_rd_d;
      w_cnt_q   <= w_cnt_d;
      b_cnt_q   <= b_cnt_d;
      rr_pnt_q  <= rr_pnt_d;
      aw_lock_q <= aw_lock_d;
      aw_idx_q  <= aw_idx_d;
      aw_pay_q  <= aw_pay_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_sched.sv
// Bench for axi_wr_sched: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based reference model.
module tb_axi_wr_sched;
  localparam int NR = 2;
  localparam int MO = 4;
  typedef logic [7:0] aw_t;
  typedef logic [8:0] w_t;   // [8:1] data, [0] last
  typedef logic [1:0] b_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  aw_t  [NR-1:0]   req_aw;
  logic [NR-1:0]   req_aw_valid, req_aw_ready;
  w_t   [NR-1:0]   req_w;
  logic [NR-1:0]   req_w_valid, req_w_ready;
  b_t   [NR-1:0]   req_b;
  logic [NR-1:0]   req_b_valid, req_b_ready;
  aw_t             axi_aw;
  logic            axi_aw_valid, axi_aw_ready;
  w_t              axi_w;
  logic            axi_w_valid, axi_w_ready;
  b_t              axi_b;
  logic            axi_b_valid, axi_b_ready;
  logic            busy;

  axi_wr_sched #(
    .NrReq(NR), .MaxOutstanding(MO),
    .axi_aw_t(aw_t), .axi_w_t(w_t), .axi_b_t(b_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_aw_i(req_aw), .req_aw_valid_i(req_aw_valid), .req_aw_ready_o(req_aw_ready),
    .req_w_i(req_w), .req_w_valid_i(req_w_valid), .req_w_ready_o(req_w_ready),
    .req_b_o(req_b), .req_b_valid_o(req_b_valid), .req_b_ready_i(req_b_ready),
    .axi_aw_o(axi_aw), .axi_aw_valid_o(axi_aw_valid), .axi_aw_ready_i(axi_aw_ready),
    .axi_w_o(axi_w), .axi_w_valid_o(axi_w_valid), .axi_w_ready_i(axi_w_ready),
    .axi_b_i(axi_b), .axi_b_valid_i(axi_b_valid), .axi_b_ready_o(axi_b_ready),
    .busy_o(busy)
  );

  int checks, errors;

  // Reference model: order queues of granted requesters, rr pointer, AW hold.
  int  w_ord[$], b_ord[$];
  int  rr;
  bit  lk;
  int  lk_idx;
  aw_t lk_pay;
  // Expectations of the current cycle, consumed at the next rising edge.
  bit  e_awv, e_aw_hs, e_wv, e_w_pop, e_b_pop;
  int  e_cand, e_w_head;
  aw_t e_aw;
  // Requester W drivers.
  int  w_left[NR], w_sent[NR], w_blen[NR];
  bit  w_rand, auto_enq;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_w();
    for (int i = 0; i < NR; i++) begin
      req_w_valid[i] = (w_left[i] > 0) && (!w_rand || $urandom_range(0, 3) != 0);
      req_w[i] = {8'(i * 16 + w_sent[i] + 1), 1'((w_sent[i] % w_blen[i]) == w_blen[i] - 1)};
    end
  endtask

  task automatic settle(string tag);
    bit            found;
    int            h;
    logic [NR-1:0] e_awr, e_wr, e_bv;
    w_t            e_w;
    b_t [NR-1:0]   e_b;
    bit            e_bready;
    drive_w();
    #1;
    if (!rst_n) begin
      w_ord.delete(); b_ord.delete(); rr = 0; lk = 0;
    end
    found = 0; e_cand = 0;
    if (lk) begin
      found = 1; e_cand = lk_idx;
    end else begin
      for (int i = 0; i < NR; i++)
        if (!found && req_aw_valid[(rr + i) % NR]) begin
          found = 1; e_cand = (rr + i) % NR;
        end
    end
    e_awv = rst_n && found && (w_ord.size() < MO) && (b_ord.size() < MO);
    e_aw = '0;
    if (e_awv) e_aw = lk ? lk_pay : req_aw[e_cand];
    e_aw_hs = e_awv && axi_aw_ready;
    e_awr = '0;
    if (e_aw_hs) e_awr[e_cand] = 1'b1;
    e_wv = 0; e_w = '0; e_wr = '0; e_w_head = 0;
    if (w_ord.size() != 0) begin
      e_w_head = w_ord[0];
      e_wv = req_w_valid[e_w_head];
      e_w = req_w[e_w_head];
      e_wr[e_w_head] = axi_w_ready;
    end
    e_w_pop = e_wv && axi_w_ready && e_w[0];
    e_bv = '0; e_b = '0; e_bready = 0;
    if (b_ord.size() != 0) begin
      h = b_ord[0];
      e_bv[h] = axi_b_valid;
      e_b[h] = axi_b;
      e_bready = req_b_ready[h];
    end
    e_b_pop = axi_b_valid && e_bready;
    check({tag, ".aw_valid"}, axi_aw_valid, e_awv);
    check({tag, ".aw"}, axi_aw, e_aw);
    check({tag, ".req_aw_ready"}, req_aw_ready, e_awr);
    check({tag, ".w_valid"}, axi_w_valid, e_wv);
    check({tag, ".w"}, axi_w, e_w);
    check({tag, ".req_w_ready"}, req_w_ready, e_wr);
    check({tag, ".req_b_valid"}, req_b_valid, e_bv);
    check({tag, ".req_b"}, req_b, e_b);
    check({tag, ".b_ready"}, axi_b_ready, e_bready);
    check({tag, ".busy"}, busy, b_ord.size() != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (e_wv && axi_w_ready) begin
        w_left[e_w_head]--; w_sent[e_w_head]++;
      end
      if (e_w_pop) void'(w_ord.pop_front());
      if (e_b_pop) void'(b_ord.pop_front());
      if (e_aw_hs) begin
        w_ord.push_back(e_cand); b_ord.push_back(e_cand);
        rr = (e_cand + 1) % NR; lk = 0;
        if (auto_enq) w_left[e_cand] += w_blen[e_cand];
      end else if (e_awv) begin
        lk = 1; lk_idx = e_cand; lk_pay = e_aw;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_w(int i, int blen, int beats);
    w_blen[i] = blen; w_left[i] = beats; w_sent[i] = 0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    req_aw_valid = '0; axi_aw_ready = 1; axi_w_ready = 1;
    axi_b_valid = 1; req_b_ready = '1; w_rand = 0; auto_enq = 0;
    while ((b_ord.size() != 0 || w_ord.size() != 0 || lk ||
            w_left[0] != 0 || w_left[1] != 0) && n < 100) begin
      settle(tag); tick(); n++;
    end
    check({tag, ".drain_in_budget"}, n < 100, 1'b1);
    axi_b_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; rr = 0; lk = 0; lk_idx = 0; lk_pay = '0;
    w_rand = 0; auto_enq = 0;
    for (int i = 0; i < NR; i++) set_w(i, 1, 0);
    req_aw = '0; req_aw_valid = '0; req_b_ready = '0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b = '0; axi_b_valid = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);

    // Reset: requests and channel activity must not leak to any valid/ready.
    req_aw_valid = 2'b11; axi_aw_ready = 1; axi_b_valid = 1; req_b_ready = 2'b11;
    settle("rst");
    check("rst.aw_valid_low", axi_aw_valid, 1'b0);
    check("rst.busy_low", busy, 1'b0);
    tick();
    settle("rst2"); tick();
    axi_b_valid = 0; req_b_ready = '0;

    // Simultaneous AW: req0 then req1; W bursts follow in that order.
    rst_n = 1; req_aw[0] = 8'h10; req_aw[1] = 8'h21; axi_w_ready = 1;
    set_w(0, 2, 2); set_w(1, 1, 1);
    settle("p029a");
    check("p029a.grant0", req_aw_ready, 2'b01);
    check("p029a.w_not_yet", axi_w_valid, 1'b0);
    tick();
    req_aw_valid = 2'b10;
    settle("p029b");
    check("p029b.grant1", req_aw_ready, 2'b10);
    check("p029b.aw1", axi_aw, 8'h21);
    check("p029b.w0_beat0", axi_w, 9'h002);
    tick();
    req_aw_valid = 2'b00;
    settle("p029c");
    check("p029c.w0_last", axi_w, 9'h005);
    tick();
    settle("p029d");
    check("p029d.w1_last", axi_w, 9'h023);
    check("p029d.w_ready1", req_w_ready, 2'b10);
    tick();
    axi_b_valid = 1; axi_b = 2'b10; req_b_ready = 2'b11;
    settle("p029e");
    check("p029e.b_to_0", req_b_valid, 2'b01);
    check("p029e.b_data", req_b, 4'b0010);
    tick();
    axi_b = 2'b01;
    settle("p029f");
    check("p029f.b_to_1", req_b, 4'b0100);
    tick();
    axi_b_valid = 0;
    settle("p029g");
    check("p029g.idle", busy, 1'b0);
    tick();

    // Req1 four-beat burst ahead of req0: req0 W stalls until req1's last beat.
    set_w(1, 4, 4); set_w(0, 1, 1);
    req_aw[1] = 8'h31; req_aw_valid = 2'b10; axi_aw_ready = 1;
    settle("p030aw"); tick();
    req_aw[0] = 8'h32; req_aw_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      settle("p030");
      check("p030.r0_stalled", req_w_ready[0], 1'b0);
      check("p030.w1_data", axi_w[8:1], 8'(8'h11 + k));
      check("p030.w1_last", axi_w[0], k == 3);
      tick();
      req_aw_valid = '0;
    end
    settle("p030r0");
    check("p030r0.r0_ready", req_w_ready[0], 1'b1);
    tick();
    drain("p030drain");

    // B withheld: four AWs fill the B-order FIFO, the fifth waits for a B pop.
    set_w(0, 1, 5); req_aw_valid = 2'b01; req_aw[0] = 8'h40;
    axi_aw_ready = 1; axi_w_ready = 1; axi_b_valid = 0; req_b_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      settle("p031fill"); check("p031fill.aw_valid", axi_aw_valid, 1'b1); tick();
    end
    for (int k = 0; k < 3; k++) begin
      settle("p031full"); check("p031full.aw_stalled", axi_aw_valid, 1'b0); tick();
    end
    axi_b_valid = 1; axi_b = 2'b11;
    settle("p031pop");
    check("p031pop.no_push_when_full", axi_aw_valid, 1'b0);
    check("p031pop.b_ready", axi_b_ready, 1'b1);
    tick();
    axi_b_valid = 0;
    settle("p031fifth"); check("p031fifth.aw_valid", axi_aw_valid, 1'b1); tick();
    drain("p031drain");

    // AW held with ready low while requests change under it.
    axi_aw_ready = 0; req_aw_valid = 2'b01; req_aw[0] = 8'hA0; req_aw[1] = 8'hB1;
    settle("p032a"); check("p032a.aw", axi_aw, 8'hA0); tick();
    req_aw_valid = 2'b10; req_aw[0] = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      settle("p032hold");
      check("p032hold.aw", axi_aw, 8'hA0);
      check("p032hold.no_ready", req_aw_ready, 2'b00);
      tick();
    end
    axi_aw_ready = 1;
    settle("p032hs"); check("p032hs.grant0", req_aw_ready, 2'b01); tick();
    settle("p032next"); check("p032next.aw1", axi_aw, 8'hB1); tick();
    set_w(0, 1, 1); set_w(1, 1, 1);
    drain("p032drain");

    // B arrives while the head requester is not ready: held, then one pop.
    req_aw_valid = 2'b11; axi_aw_ready = 1; req_aw[0] = 8'h50; req_aw[1] = 8'h51;
    set_w(0, 1, 1); set_w(1, 1, 1); axi_w_ready = 1; req_b_ready = 2'b00;
    settle("p033aw0"); tick();
    req_aw_valid = 2'b10;
    settle("p033aw1"); tick();
    req_aw_valid = 2'b00;
    settle("p033w"); tick();
    axi_b_valid = 1; axi_b = 2'b01;
    for (int k = 0; k < 2; k++) begin
      settle("p033hold");
      check("p033hold.b_ready", axi_b_ready, 1'b0);
      check("p033hold.b_valid0", req_b_valid, 2'b01);
      tick();
    end
    req_b_ready = 2'b01;
    settle("p033pop"); check("p033pop.b_ready", axi_b_ready, 1'b1); tick();
    req_b_ready = 2'b00;
    settle("p033after");
    check("p033after.head1", req_b_valid, 2'b10);
    check("p033after.busy", busy, 1'b1);
    tick();
    drain("p033drain");

    // Reset in the middle of a four-beat burst.
    req_aw_valid = 2'b01; req_aw[0] = 8'h60; set_w(0, 4, 4);
    settle("p034aw"); tick();
    req_aw_valid = 2'b00;
    settle("p034b1"); tick();
    settle("p034b2"); tick();
    rst_n = 0; req_aw_valid = 2'b11; axi_b_valid = 1; req_b_ready = 2'b11;
    settle("p034rst");
    check("p034rst.busy", busy, 1'b0);
    check("p034rst.w_valid", axi_w_valid, 1'b0);
    check("p034rst.aw_valid", axi_aw_valid, 1'b0);
    tick();
    rst_n = 1; axi_b_valid = 0; req_aw[0] = 8'h5A; set_w(0, 1, 1); set_w(1, 1, 0);
    settle("p034after");
    check("p034after.grant0", req_aw_ready, 2'b01);
    check("p034after.aw", axi_aw, 8'h5A);
    tick();
    req_aw_valid = 2'b00;
    drain("p034drain");

    // Randomized traffic on every channel.
    w_rand = 1; auto_enq = 1;
    for (int i = 0; i < NR; i++) set_w(i, $urandom_range(1, 3), 0);
    for (int n = 0; n < 400; n++) begin
      req_aw_valid = NR'($urandom_range(0, 3));
      for (int i = 0; i < NR; i++) req_aw[i] = aw_t'($urandom);
      axi_aw_ready = ($urandom_range(0, 3) != 0);
      axi_w_ready  = ($urandom_range(0, 3) != 0);
      axi_b_valid  = 1'($urandom_range(0, 1));
      axi_b        = b_t'($urandom);
      req_b_ready  = NR'($urandom_range(0, 3));
      settle("rand"); tick();
    end
    drain("rand_drain");
    settle("final"); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
